fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter WAIT_LIMIT, default 15, maximum FETCH cycles without mem_r before timeout fault; 0 disables timeout; legal range 0..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request one instruction fetch at current PC; honoured only in IDLE.
REQ-005 PC  input  16  current program counter from the PC mux.
REQ-006 flush  input  1  abort the fetch in progress (taken branch or exception).
REQ-007 mem_en  output  1  memory read request, held until ready or abort.
REQ-008 mem_addr  output  16  read address, equal to the PC latched on start.
REQ-009 mem_r  input  1  memory ready; mem_data valid in the same cycle.
REQ-010 mem_data  input  16  read data.
REQ-011 IR  output  16  fetched instruction register.
REQ-012 ir_valid  output  1  IR holds an instruction not yet consumed.
REQ-013 ir_ack  input  1  decode consumes IR.
REQ-014 LD_PC  output  1  one-cycle PC load strobe to the PC mux.
REQ-015 PC_SEL  output  2  PC source select; constant 2'd0 (INC, PC+2).
REQ-016 fault  output  1  sticky fetch fault.
REQ-017 fault_code  output  2  0 = none, 1 = misaligned PC, 2 = memory timeout.

Function
REQ-018 States SHALL be IDLE, FETCH, HOLD and FAULT, with the state register updating on the rising edge of clk.
REQ-019 In IDLE, start=1 with PC[0]=0 SHALL latch mem_addr<=PC, clear wait_cnt and enter FETCH, so mem_en rises in the following cycle.
REQ-020 In IDLE, start=1 with PC[0]=1 SHALL set fault=1 and fault_code=1 and enter FAULT; mem_en SHALL never assert for that request.
REQ-021 In FETCH, mem_en SHALL be 1 and mem_addr SHALL be stable.
REQ-022 In FETCH, an edge sampling mem_r=1 and flush=0 SHALL load IR<=mem_data, set ir_valid<=1, set registered LD_PC<=1 and enter HOLD.
REQ-023 LD_PC SHALL be high for exactly one cycle (the first HOLD cycle), so the PC mux advances PC by 2 once per fetched instruction.
REQ-024 In FETCH, mem_r=0 SHALL increment the 8-bit wait_cnt.
REQ-025 In FETCH with WAIT_LIMIT != 0, mem_r=0 and wait_cnt == WAIT_LIMIT-1 SHALL set fault=1 and fault_code=2 and enter FAULT, so timeout occurs after WAIT_LIMIT unready cycles.
REQ-026 In FETCH, flush=1 SHALL enter IDLE with no IR update and no LD_PC; flush SHALL win over a simultaneous mem_r=1 and over a simultaneous timeout.
REQ-027 In HOLD, IR and ir_valid SHALL remain stable until ir_ack=1 is sampled; that edge SHALL clear ir_valid and enter IDLE.
REQ-028 In HOLD, flush=1 SHALL clear ir_valid and enter IDLE; the already-issued LD_PC SHALL not be retracted.
REQ-029 start SHALL be ignored outside IDLE; back-to-back fetches therefore require at least one IDLE cycle, which guarantees that PC has been updated.
REQ-030 FAULT SHALL be absorbing: mem_en=0, LD_PC=0, fault and fault_code held, and start and flush ignored until reset.
REQ-031 mem_en and mem_addr SHALL not change during FETCH except on exit.
REQ-032 PC_SEL SHALL be 2'd0 in every cycle.

Reset
REQ-033 rst_n=0 SHALL immediately force state=IDLE, mem_en=0, mem_addr=0, IR=0, ir_valid=0, LD_PC=0, fault=0, fault_code=0 and wait_cnt=0, including mid-FETCH or mid-HOLD.
REQ-034 The first fetch after rst_n rises SHALL require a new start.

Verification
REQ-035 Nominal fetch: PC=0x3000, start pulse, mem_r raised on the 3rd mem_en cycle with mem_data=0x1234 -> mem_addr=0x3000, IR=0x1234, ir_valid=1, a single-cycle LD_PC with PC_SEL=0.
REQ-036 Stall: ir_ack held low for 5 cycles -> IR and ir_valid stable and no further LD_PC; ir_ack=1 -> ir_valid=0 next cycle and state IDLE.
REQ-037 Misaligned: PC=0x3001, start -> fault=1, fault_code=1, mem_en never 1; a later start is ignored.
REQ-038 Timeout: WAIT_LIMIT=4, mem_r held 0 -> mem_en high exactly 4 cycles, then fault_code=2 and mem_en=0.
REQ-039 Flush race: flush=1 and mem_r=1 in the same FETCH cycle with mem_data=0xBEEF -> IR unchanged, LD_PC never 1, ir_valid=0, state IDLE.
REQ-040 Async reset: rst_n pulled low mid-FETCH between clock edges -> mem_en and all other outputs 0 before the next clk edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit.
// Issues one memory read per start request, captures the returned word into IR, pulses LD_PC
// once per fetched instruction, and holds IR until decode acknowledges it. Misaligned PCs and
// memory timeouts latch a sticky fault that only reset clears.
module fetch_unit #(
   parameter int unsigned WAIT_LIMIT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [15:0] pc_i,
   input  logic        flush_i,
   output logic        mem_en_o,
   output logic [15:0] mem_addr_o,
   input  logic        mem_r_i,
   input  logic [15:0] mem_data_i,
   output logic [15:0] ir_o,
   output logic        ir_valid_o,
   input  logic        ir_ack_i,
   output logic        ld_pc_o,
   output logic [1:0]  pc_sel_o,
   output logic        fault_o,
   output logic [1:0]  fault_code_o
);

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StHold,
      StFault
   } state_e;

   localparam logic [1:0] FaultNone     = 2'd0;
   localparam logic [1:0] FaultMisalign = 2'd1;
   localparam logic [1:0] FaultTimeout  = 2'd2;
   localparam logic [1:0] PcSelInc      = 2'd0;

   // WAIT_LIMIT of 0 disables the timeout; WaitLast is then unused.
   localparam bit         TimeoutEn = (WAIT_LIMIT != 0);
   localparam logic [7:0] WaitLast  = (WAIT_LIMIT == 0) ? 8'd0 : 8'(WAIT_LIMIT - 1);

   state_e      state_q, state_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [15:0] ir_q, ir_d;
   logic        ir_valid_q, ir_valid_d;
   logic        ld_pc_q, ld_pc_d;
   logic        fault_q, fault_d;
   logic [1:0]  fault_code_q, fault_code_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;

   // State and datapath registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         mem_addr_q   <= 16'h0000;
         ir_q         <= 16'h0000;
         ir_valid_q   <= 1'b0;
         ld_pc_q      <= 1'b0;
         fault_q      <= 1'b0;
         fault_code_q <= FaultNone;
         wait_cnt_q   <= 8'd0;
      end else begin
         state_q      <= state_d;
         mem_addr_q   <= mem_addr_d;
         ir_q         <= ir_d;
         ir_valid_q   <= ir_valid_d;
         ld_pc_q      <= ld_pc_d;
         fault_q      <= fault_d;
         fault_code_q <= fault_code_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

   // Next-state logic; in FETCH, flush beats both a ready memory and a timeout.
   always_comb begin
      state_d      = state_q;
      mem_addr_d   = mem_addr_q;
      ir_d         = ir_q;
      ir_valid_d   = ir_valid_q;
      ld_pc_d      = 1'b0;
      fault_d      = fault_q;
      fault_code_d = fault_code_q;
      wait_cnt_d   = wait_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               if (pc_i[0]) begin
                  // Misaligned request never reaches memory.
                  fault_d      = 1'b1;
                  fault_code_d = FaultMisalign;
                  state_d      = StFault;
               end else begin
                  mem_addr_d = pc_i;
                  wait_cnt_d = 8'd0;
                  state_d    = StFetch;
               end
            end
         end

         StFetch: begin
            if (flush_i) begin
               state_d = StIdle;
            end else if (mem_r_i) begin
               ir_d       = mem_data_i;
               ir_valid_d = 1'b1;
               ld_pc_d    = 1'b1;
               state_d    = StHold;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
               if (TimeoutEn && (wait_cnt_q == WaitLast)) begin
                  fault_d      = 1'b1;
                  fault_code_d = FaultTimeout;
                  state_d      = StFault;
               end
            end
         end

         StHold: begin
            // LD_PC already went out on entry; leaving early does not undo it.
            if (flush_i || ir_ack_i) begin
               ir_valid_d = 1'b0;
               state_d    = StIdle;
            end
         end

         StFault: begin
            state_d = StFault;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs: memory request is a pure decode of FETCH so it drops as soon as reset asserts.
   always_comb begin
      mem_en_o     = (state_q == StFetch);
      mem_addr_o   = mem_addr_q;
      ir_o         = ir_q;
      ir_valid_o   = ir_valid_q;
      ld_pc_o      = ld_pc_q;
      pc_sel_o     = PcSelInc;
      fault_o      = fault_q;
      fault_code_o = fault_code_q;
   end

endmodule
